dspl_mux_drv: RTL and testbench
===============================

// Module: dspl_mux_drv
// PURPOSE
//  Parametrised time-multiplexed 7-segment driver, successor to the fixed 8-digit display driver.
//  Scans NUM_DIGITS digits. Each digit is described by a 6-bit field {en, hex[3:0], dp}.
//  Input fields are double-buffered: a load strobe captures them, and the new set becomes visible only at a frame boundary (tear-free).
//  Sits between datapath/debug logic and the board anode/cathode pins.
// PARAMETERS
//  NUM_DIGITS   8       digits scanned per frame (1..16)
//  REFRESH_DIV  100000  clock cycles each digit is held (>=2)
//  BLINK_FRAMES 64      frames per blink half-period (used only with DSPL_BLINK_EN)
// PORTS
//  clock       in   1              system clock, rising edge
//  reset       in   1              asynchronous, active-high
//  digits_i    in   6*NUM_DIGITS   field k at [6k+5:6k] = {en, hex[3:0], dp}
//  load_i      in   1              capture digits_i into shadow register
//  blink_i     in   NUM_DIGITS     per-digit blink mask (present only with DSPL_BLINK_EN)
//  an          out  NUM_DIGITS     anodes, active-low, one-hot-low when a digit is lit
//  dec_cat     out  8              {CA,CB,CC,CD,CE,CF,CG,DP}, active-low
//  frame_tick  out  1              1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  - Reset (async, any time): div_cnt=0, idx=0, shadow=0, active=0, pending=0, an=all 1, dec_cat=8'hFF, frame_tick=0, blink phase=0.
//  - div_cnt counts 0..REFRESH_DIV-1. At the terminal count it returns to 0 and idx advances.
//  - idx wraps from NUM_DIGITS-1 to 0. This wrap is the frame boundary; frame_tick=1 in the cycle after the wrap edge.
//  - Period of frame_tick: NUM_DIGITS*REFRESH_DIV cycles.
//  - load_i=1: shadow<=digits_i and pending<=1 on the same edge. Repeated loads overwrite the shadow; last load wins.
//  - Frame boundary with pending=1: active<=shadow and pending<=0.
//  - Frame boundary coinciding with load_i=1:
//      - active takes the shadow value held before this edge;
//      - shadow takes the new digits_i;
//      - pending stays 1, so the new value commits at the next boundary.
//  - Outputs are registered and reflect active[idx], 1 cycle after idx changes:
//      - en=1: an = ~(1<<idx); dec_cat[7:1] = active-low hex segment pattern;
//      - en=1: dec_cat[0] = ~dp;
//      - en=0: an[idx]=1 (all anodes high); dec_cat=8'hFF.
//  - Hex patterns {a..g} active-high lit. The table is complete; no don't-cares.
//    0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47
//  - Anode blanking: no dedicated dead time. Anode and cathode update on the same edge.
//  - Reset mid-frame: scan restarts at digit 0. Display blank until the first load is committed.
// CONFIGURATION
//  DSPL_BLINK_EN defined:
//    - blink_i port and BLINK_FRAMES are active;
//    - a frame counter toggles the blink phase every BLINK_FRAMES frame boundaries;
//    - phase=1 and blink_i[idx]=1: digit forced off (an all 1, dec_cat=8'hFF).
//    - blink_i is sampled live, not double-buffered.
//  DSPL_BLINK_EN undefined:
//    - blink_i port absent; no frame counter;
//    - behaviour identical to the above with blink mask all 0.
// TESTING (NUM_DIGITS=8, REFRESH_DIV=4, BLINK_FRAMES=2)
//  1. Assert reset mid-scan -> an=8'hFF, dec_cat=8'hFF, frame_tick=0 immediately (no clock edge).
//     Release -> frame_tick pulses every 32 cycles.
//  2. Load digit0={1,4'h3,0}, others en=0, wait one boundary.
//     -> During idx 0: an=8'hFE, dec_cat=8'h0D.
//     -> Other slots: an=8'hFF, dec_cat=8'hFF.
//  3. Load digit7={1,4'hA,1} mid-frame.
//     -> Display unchanged until the next frame_tick.
//     -> Then at idx 7: an=8'h7F, dec_cat=8'h10.
//  4. Pulse load_i on the exact wrap edge with value X, previous shadow Y pending.
//     -> Y shown this frame; X shown from the following frame.
//  5. Loads X, then Z inside one frame -> only Z ever appears.
//  6. DSPL_BLINK_EN, blink_i=8'h01, digit0 lit.
//     -> Digit0 alternately lit for 2 frames, then blank for 2 frames.
//     -> Other digits unaffected.

Source files
------------

// File: rtl/dspl_mux_drv.sv
`default_nettype none
// ============================================================================
// Module      : dspl_mux_drv
// Description : Time-multiplexed 7-segment driver with tear-free double-
//               buffered digit fields. Optional DSPL_BLINK_EN adds a per-digit
//               blink mask gated by a frame-counted blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
module dspl_mux_drv #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
`ifdef DSPL_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_i,
`endif
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              dec_cat,
    output logic                    frame_tick
);

    localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [c_DIV_W-1:0]      r_div_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [6*NUM_DIGITS-1:0] r_shadow;
    logic [6*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_dec_cat;
    logic                    r_frame_tick;

    logic                    w_div_tc;
    logic                    w_wrap;
    logic [5:0]              w_fields [NUM_DIGITS];
    logic [5:0]              w_field;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic                    w_blank;

    assign w_div_tc = (r_div_cnt == c_DIV_W'(REFRESH_DIV - 1));
    assign w_wrap   = w_div_tc && (r_idx == c_IDX_W'(NUM_DIGITS - 1));

    // Scan timing: digit hold counter and digit index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_div_tc) begin
            r_div_cnt <= '0;
            r_idx     <= w_wrap ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    // A load on the wrap edge itself still commits the older shadow first;
    // the fresh value stays pending for the following frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load_i) begin
                r_shadow <= digits_i;
            end
            if (w_wrap && r_pending) begin
                r_active <= r_shadow;
            end
            if (load_i) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_field
            assign w_fields[k] = r_active[6*k +: 6];
        end
    endgenerate

    assign w_field  = w_fields[r_idx];
    assign w_an_sel = ~(NUM_DIGITS'(1) << r_idx);

    // Active-high {a,b,c,d,e,f,g}
    always_comb begin
        w_seg = 7'h00;
        case (w_field[4:1])
            4'h0: w_seg = 7'h7E;
            4'h1: w_seg = 7'h30;
            4'h2: w_seg = 7'h6D;
            4'h3: w_seg = 7'h79;
            4'h4: w_seg = 7'h33;
            4'h5: w_seg = 7'h5B;
            4'h6: w_seg = 7'h5F;
            4'h7: w_seg = 7'h70;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h7B;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h1F;
            4'hC: w_seg = 7'h4E;
            4'hD: w_seg = 7'h3D;
            4'hE: w_seg = 7'h4F;
            default: w_seg = 7'h47;
        endcase
    end

`ifdef DSPL_BLINK_EN
    localparam int c_BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_BF_W-1:0] r_frm_cnt;
    logic              r_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frm_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_wrap) begin
            if (r_frm_cnt == c_BF_W'(BLINK_FRAMES - 1)) begin
                r_frm_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_frm_cnt <= r_frm_cnt + c_BF_W'(1);
            end
        end
    end

    // Mask is sampled live so blinking can be changed without a reload
    assign w_blank = r_phase & blink_i[r_idx];
`else
    logic w_unused_blink_cfg;
    assign w_unused_blink_cfg = (BLINK_FRAMES > 0);
    assign w_blank            = 1'b0;
`endif

    // Anode and cathode update together on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_an         <= '1;
            r_dec_cat    <= 8'hFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap;
            if (w_field[5] && !w_blank) begin
                r_an      <= w_an_sel;
                r_dec_cat <= {~w_seg, ~w_field[0]};
            end else begin
                r_an      <= '1;
                r_dec_cat <= 8'hFF;
            end
        end
    end

    assign an         = r_an;
    assign dec_cat    = r_dec_cat;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_dspl_mux_drv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dspl_mux_drv
// Description : Randomised bench for dspl_mux_drv against a frame-arithmetic
//               reference model (NUM_DIGITS=8, REFRESH_DIV=4, BLINK_FRAMES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dspl_mux_drv;

    localparam int ND = 8;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = ND * RD;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [6*ND-1:0] digits_i = '0;
    logic            load_i = 1'b0;
    logic [ND-1:0]   blink_i = 8'h01;
    logic [ND-1:0]   an;
    logic [7:0]      dec_cat;
    logic            frame_tick;

    dspl_mux_drv #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_FRAMES(BF)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .digits_i  (digits_i),
        .load_i    (load_i),
`ifdef DSPL_BLINK_EN
        .blink_i   (blink_i),
`endif
        .an        (an),
        .dec_cat   (dec_cat),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    int              n_cmp = 0;
    int              n_err = 0;
    int              e     = 0;
    int              ledge [$];
    logic [6*ND-1:0] lval  [$];
    logic [ND-1:0]   bl_used = '0;
    logic [6:0]      seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Expected {frame_tick, an, dec_cat} just after edge ed (edge 0 = reset state).
    // The displayed set in a frame is the last load strictly before its start edge.
    function automatic logic [16:0] model(input int ed, input logic [ND-1:0] bl);
        int              p    = ed - 1;
        int              idx  = (p / RD) % ND;
        int              bnd  = (p / FR) * FR;
        logic [6*ND-1:0] act  = '0;
        logic [5:0]      f;
        logic            ph;
        logic [ND-1:0]   an_x = '1;
        logic [7:0]      cat_x = 8'hFF;
        foreach (ledge[i]) if (ledge[i] < bnd) act = lval[i];
        f = act[6*idx +: 6];
`ifdef DSPL_BLINK_EN
        ph = (((p / FR) / BF) % 2) == 1;
`else
        ph = 1'b0;
`endif
        if (f[5] && !(ph && bl[idx])) begin
            an_x  = ~(ND'(1) << idx);
            cat_x = {~seg_tab[f[4:1]], ~f[0]};
        end
        return {(ed % FR == 0), an_x, cat_x};
    endfunction

    task automatic rand_digits();
        for (int k = 0; k < ND; k++)
            digits_i[6*k +: 6] = {($urandom_range(3) != 0), 4'($urandom_range(15)), 1'($urandom_range(1))};
    endtask

    // Inputs applied for edge n
    task automatic drive(input int n);
        load_i = 1'b0;
        case (n)
            5: begin
                digits_i       = '0;
                digits_i[5:0]  = 6'b1_0011_0;
                load_i         = 1'b1;
            end
            50: begin
                digits_i[47:42] = 6'b1_1010_1;
                load_i          = 1'b1;
            end
            90, 96, 105, 110: begin
                rand_digits();
                load_i = 1'b1;
            end
            default: begin
                if (n > 130 && ((n % FR == 0 && $urandom_range(1) == 1) || $urandom_range(15) == 0)) begin
                    rand_digits();
                    load_i = 1'b1;
                end
            end
        endcase
        if (load_i) begin
            ledge.push_back(n);
            lval.push_back(digits_i);
        end
`ifdef DSPL_BLINK_EN
        if (n > 300 && $urandom_range(63) == 0) blink_i = 8'($urandom);
        bl_used = blink_i;
`else
        bl_used = '0;
`endif
    endtask

    task automatic step();
        logic [16:0] m;
        @(posedge clock);
        e++;
        #1;
        m = model(e, bl_used);
        check("frame_tick", {15'b0, frame_tick}, {15'b0, m[16]});
        check("an",         {8'b0, an},          {8'b0, m[15:8]});
        check("dec_cat",    {8'b0, dec_cat},     {8'b0, m[7:0]});
        drive(e + 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_an",  {8'b0, an},          16'h00FF);
        check("reset_cat", {8'b0, dec_cat},     16'h00FF);
        check("reset_ft",  {15'b0, frame_tick}, 16'h0000);
        reset = 1'b0;
        e = 0;
        drive(1);
        repeat (1200) step();

        // Asynchronous reset in the middle of a digit slot
        @(posedge clock);
        #3;
        reset  = 1'b1;
        load_i = 1'b0;
        #1;
        check("async_an",  {8'b0, an},          16'h00FF);
        check("async_cat", {8'b0, dec_cat},     16'h00FF);
        check("async_ft",  {15'b0, frame_tick}, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        e = 0;
        ledge.delete();
        lval.delete();
        drive(1);
        repeat (1500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
